// File: rtl/port_bcd_display_pkg.sv
// Shared constants for the output-port BCD display: segment patterns,
// converter states and the leading-zero blanking helper.
package port_display_pkg;

    localparam int unsigned BCD_DIGITS = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // A digit is blanked when it and every more significant digit are zero;
    // the ones digit is never blanked.
    function automatic logic [BCD_DIGITS-1:0] lead_blank(input logic [4*BCD_DIGITS-1:0] bcd);
        logic [BCD_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int unsigned i = BCD_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
            mask[i]    = zero_above;
        end
        return mask;
    endfunction

endpackage

// File: rtl/port_bcd_display_if.sv
// Output-port value in, seven-segment pins and busy flag out.
interface port_bcd_display_if #(
    parameter int unsigned DIN_W = 10
);
    logic [DIN_W-1:0] value;
    logic [6:0]       seg;
    logic [3:0]       an;
    logic             busy;

    modport master (output value, input seg, input an, input busy);
    modport slave  (input value, output seg, output an, output busy);
endinterface

// File: rtl/port_bcd_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one iteration per clock.
// Under BCD_BLANK_EN it also latches a leading-zero blanking mask.
module bin2bcd_seq
    import port_display_pkg::*;
#(
    parameter int unsigned DIN_W = 10
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [DIN_W-1:0]          value_i,
    output logic [4*BCD_DIGITS-1:0]   bcd_o,
`ifdef BCD_BLANK_EN
    output logic [BCD_DIGITS-1:0]     blank_o,
`endif
    output logic                      busy_o
);

    localparam int unsigned BCD_W     = 4 * BCD_DIGITS;
    localparam int unsigned SH_W      = BCD_W + DIN_W;
    localparam logic [3:0]  ITER_LAST = 4'(DIN_W - 1);

    conv_state_e       state_q, state_d;
    logic [DIN_W-1:0]  cap_q, cap_d;
    logic [SH_W-1:0]   sh_q, sh_d, sh_adj;
    logic [3:0]        iter_q, iter_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              busy_q, busy_d;
`ifdef BCD_BLANK_EN
    logic [BCD_DIGITS-1:0] blank_q, blank_d;
`endif

    always_comb begin
        sh_adj = sh_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (sh_q[DIN_W + 4*i +: 4] >= 4'd5)
                sh_adj[DIN_W + 4*i +: 4] = sh_q[DIN_W + 4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        sh_d    = sh_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
`ifdef BCD_BLANK_EN
        blank_d = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (value_i != cap_q) begin
                    cap_d   = value_i;
                    sh_d    = {{BCD_W{1'b0}}, value_i};
                    iter_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sh_d   = {sh_adj[SH_W-2:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == ITER_LAST)
                    state_d = LOAD;
            end
            LOAD: begin
                bcd_d   = sh_q[SH_W-1:DIN_W];
`ifdef BCD_BLANK_EN
                blank_d = lead_blank(sh_q[SH_W-1:DIN_W]);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cap_q   <= '0;
            sh_q    <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q <= 4'b1110;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            sh_q    <= sh_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
`ifdef BCD_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign bcd_o  = bcd_q;
    assign busy_o = busy_q;
`ifdef BCD_BLANK_EN
    assign blank_o = blank_q;
`endif

endmodule

// File: rtl/port_bcd_display.sv
// 4-digit common-anode display of the 10-bit output port, with digit scanner.
// Define BCD_BLANK_EN to blank leading zero digits.
module port_bcd_display
    import port_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DIN_W       = 10
) (
    input  logic               clk,
    input  logic               nrst,
    port_bcd_display_if.slave  bus
);

    localparam int unsigned CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    busy;
`ifdef BCD_BLANK_EN
    logic [BCD_DIGITS-1:0]   blank;
`endif

    bin2bcd_seq #(
        .DIN_W (DIN_W)
    ) u_bin2bcd (
        .clk     (clk),
        .nrst    (nrst),
        .value_i (bus.value),
        .bcd_o   (bcd),
`ifdef BCD_BLANK_EN
        .blank_o (blank),
`endif
        .busy_o  (busy)
    );

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    // Pins are re-registered every cycle from the current index, so a new
    // converted value shows up one cycle after LOAD wherever the scan is.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_decode(bcd[{idx_q, 2'b00} +: 4]);
`ifdef BCD_BLANK_EN
        if (blank[idx_q]) begin
            an_d  = '1;
            seg_d = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.busy = busy;

endmodule

// File: doc/port_bcd_display.md
Name: port_bcd_display

Overview:
- Consumes the 10-bit memory-mapped output port value (0..1023) and shows it in decimal on a 4-digit common-anode seven-segment display.
- Contains a sequential binary-to-BCD converter (shift-add-3, one iteration per clock) and a time-multiplexed digit scanner.
- Sits directly downstream of the CPU output-port register, between it and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays enabled; legal range ≥ 2.
- DIN_W, 10, input value width; fixed at 10 for a 4-digit display.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- value  input  10  binary value from the output-port register; not assumed stable.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit enables, active-low; an[0] = ones digit, an[3] = thousands digit.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (async, nrst=0) forces:
  - state IDLE; captured value 0; displayed BCD 0000.
  - digit index 0; refresh counter 0.
  - seg=7'b1111111, an=4'b1111, busy=0.
- Converter FSM, states IDLE, CONV, LOAD:
  - IDLE: if value != captured, then captured<=value, shift reg<={16'b0,value}, iter<=0, go CONV. Otherwise stay.
  - CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift the whole 26-bit register left by 1; iter++. After the 10th iteration (iter==9), go LOAD.
  - LOAD: disp_bcd<=shift reg[25:10]; go IDLE.
  - busy=1 in CONV and LOAD; registered, so it is high the cycle after capture.
- Latency:
  - Capture at edge N; 10 CONV edges N+1..N+10; LOAD at N+11.
  - New digits are visible on seg at edge N+12.
- Input changes during CONV/LOAD are ignored. On return to IDLE, value is re-compared against captured and reconverts if different; the last value always wins.
- disp_bcd only changes in LOAD; the display never shows partial results.
- Scanner:
  - Refresh counter counts 0..REFRESH_DIV-1 continuously and wraps to 0.
  - At terminal count, digit index increments mod 4 (3→0).
  - Outputs are registered every cycle from the current index: an<=~(4'b0001<<idx), seg<=decode(disp_bcd nibble idx).
  - A disp_bcd change reaches seg within 1 cycle regardless of scan position.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble = 1111111 (unreachable; defensive).
- Reset mid-conversion: conversion aborted; display returns to 0000 with blank outputs until the first registered update after release.

Optional Feature:
- Macro BCD_BLANK_EN.
- Defined: leading-zero digits are blanked (seg=1111111, an bit held high for that digit slot).
  - Digit 0 is never blanked, so value 0 shows "0" and value 7 shows "7" only.
  - The blanking mask is computed from disp_bcd at LOAD and stored alongside it.
- Undefined: all four digits are always displayed, including leading zeros (7 → "0007").

Decomposition:
- Shared package port_display_pkg holds:
  - seven-segment decode constants (SEG_0..SEG_9, SEG_BLANK);
  - converter state enum (IDLE, CONV, LOAD);
  - BCD_DIGITS=4.
- One natural sub-module, bin2bcd_seq: converter FSM plus shift register.
  - Interface: clk, nrst, value, bcd[15:0], busy, plus blank mask under BCD_BLANK_EN.
- Scanner and decode stay in the top.

Test Plan:
- Reset hold 5 cycles, release with value=0 → seg=1000000 on all digit slots; an cycles 1110→1101→1011→0111→1110, each held REFRESH_DIV cycles (run with REFRESH_DIV=4).
- value 0→1023 at edge N → busy high N+1..N+11; idx0 shows 0110000 (3) from edge N+12; idx1 shows 0100100, idx2 shows 1000000, idx3 shows 1111001.
- value=512, then 37 at N+4 mid-conversion → display shows 0512 first, then reconverts and settles to 0037 (blanked to "37" with BCD_BLANK_EN); no intermediate digit patterns on seg.
- value=9 with BCD_BLANK_EN → an pulses only 1110 with seg=0010000, other slots stay 1111; without the macro all four digits are shown as 0009.
- Assert nrst during CONV → seg=1111111, an=1111, busy=0 immediately (asynchronous); after release, display 0 then converts the current value.
- Boundary sweep of values 0, 9, 10, 99, 100, 999, 1000 → correct decimal digits each time; refresh wrap 3→0 never skips or repeats a slot.
